// File: rtl/exe_stage.sv
// EXE pipeline stage: operand select, single-cycle ALU, iterative shift-add multiplier
// and the EXE/MEM pipeline register with bubble insertion while stalled.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_RegWrite,
    input  logic        EXE_mem_to_reg,
    input  logic        EXE_memwrite,
    input  logic        EXE_jal,
    input  logic        EXE_alua,
    input  logic        EXE_alub,
    input  logic [3:0]  EXE_aluOp,
    input  logic [31:0] EXE_PC,
    input  logic [31:0] EXE_A,
    input  logic [31:0] EXE_B,
    input  logic [31:0] EXE_IMM32,
    input  logic [4:0]  EXE_writereg_num,
    output logic        MEM_RegWrite,
    output logic        MEM_mem_to_reg,
    output logic        MEM_memwrite,
    output logic [31:0] MEM_result,
    output logic [31:0] MEM_B,
    output logic [4:0]  MEM_writereg_num,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

    mul_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q, mplier_q, acc_q;

    logic        rw_q, m2r_q, mw_q;
    logic [31:0] result_q, b_q;
    logic [4:0]  wr_q;

    logic [31:0] op_x, op_y, result;
    logic        mul_req;

    assign op_x    = EXE_alua ? {27'b0, EXE_IMM32[10:6]} : EXE_A;
    assign op_y    = EXE_alub ? EXE_IMM32 : EXE_B;
    assign mul_req = (EXE_aluOp == 4'd12) && !EXE_jal;
    // Gated by rst so an in-flight or pending multiply never stalls upstream during reset.
    assign stall   = rst && (((state_q == IDLE) && mul_req) || (state_q == BUSY));

    always_comb begin
        result = '0;
        if (EXE_jal) begin
            result = EXE_PC;
        end else begin
            case (EXE_aluOp)
                4'd0:    result = op_x + op_y;
                4'd1:    result = op_x - op_y;
                4'd2:    result = op_x & op_y;
                4'd3:    result = op_x | op_y;
                4'd4:    result = op_x ^ op_y;
                4'd5:    result = ~(op_x | op_y);
                4'd6:    result = ($signed(op_x) < $signed(op_y)) ? 32'd1 : '0;
                4'd7:    result = (op_x < op_y) ? 32'd1 : '0;
                4'd8:    result = op_y << op_x[4:0];
                4'd9:    result = op_y >> op_x[4:0];
                4'd10:   result = $unsigned($signed(op_y) >>> op_x[4:0]);
                4'd11:   result = op_y << 16;
                4'd12:   result = (state_q == DONE) ? acc_q : '0;
                default: result = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_req) begin
                        mcand_q  <= op_x;
                        mplier_q <= op_y;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            mw_q     <= 1'b0;
            result_q <= '0;
            b_q      <= '0;
            wr_q     <= '0;
        end else if (stall) begin
            rw_q     <= 1'b0;
            m2r_q    <= 1'b0;
            mw_q     <= 1'b0;
            result_q <= '0;
            b_q      <= '0;
            wr_q     <= '0;
        end else begin
            rw_q     <= EXE_RegWrite;
            m2r_q    <= EXE_mem_to_reg;
            mw_q     <= EXE_memwrite;
            result_q <= result;
            b_q      <= EXE_B;
            wr_q     <= EXE_writereg_num;
        end
    end

    assign MEM_RegWrite     = rw_q;
    assign MEM_mem_to_reg   = m2r_q;
    assign MEM_memwrite     = mw_q;
    assign MEM_result       = result_q;
    assign MEM_B            = b_q;
    assign MEM_writereg_num = wr_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expectations pushed at issue, popped when MEM outputs appear.
module tb_exe_stage;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [31:0] res;
        logic [31:0] b;
        logic [4:0]  wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_RegWrite, EXE_mem_to_reg, EXE_memwrite, EXE_jal, EXE_alua, EXE_alub;
    logic [3:0]  EXE_aluOp;
    logic [31:0] EXE_PC, EXE_A, EXE_B, EXE_IMM32;
    logic [4:0]  EXE_writereg_num;
    logic        MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite;
    logic [31:0] MEM_result, MEM_B;
    logic [4:0]  MEM_writereg_num;
    logic        stall;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    exe_stage dut (
        .clk(clk), .rst(rst),
        .EXE_RegWrite(EXE_RegWrite), .EXE_mem_to_reg(EXE_mem_to_reg),
        .EXE_memwrite(EXE_memwrite), .EXE_jal(EXE_jal),
        .EXE_alua(EXE_alua), .EXE_alub(EXE_alub), .EXE_aluOp(EXE_aluOp),
        .EXE_PC(EXE_PC), .EXE_A(EXE_A), .EXE_B(EXE_B), .EXE_IMM32(EXE_IMM32),
        .EXE_writereg_num(EXE_writereg_num),
        .MEM_RegWrite(MEM_RegWrite), .MEM_mem_to_reg(MEM_mem_to_reg),
        .MEM_memwrite(MEM_memwrite), .MEM_result(MEM_result), .MEM_B(MEM_B),
        .MEM_writereg_num(MEM_writereg_num), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        return {MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite, MEM_result, MEM_B, MEM_writereg_num};
    endfunction

    function automatic exp_t predict();
        logic [31:0] x, y, r;
        x = EXE_alua ? {27'b0, EXE_IMM32[10:6]} : EXE_A;
        y = EXE_alub ? EXE_IMM32 : EXE_B;
        case (EXE_aluOp)
            4'd0:    r = x + y;
            4'd1:    r = x - y;
            4'd2:    r = x & y;
            4'd3:    r = x | y;
            4'd4:    r = x ^ y;
            4'd5:    r = ~(x | y);
            4'd6:    r = {31'b0, $signed(x) < $signed(y)};
            4'd7:    r = {31'b0, x < y};
            4'd8:    r = y << x[4:0];
            4'd9:    r = y >> x[4:0];
            4'd10:   r = $unsigned($signed(y) >>> x[4:0]);
            4'd11:   r = {y[15:0], 16'h0};
            4'd12:   r = x * y;
            default: r = 32'h0;
        endcase
        if (EXE_jal) r = EXE_PC;
        return {EXE_RegWrite, EXE_mem_to_reg, EXE_memwrite, r, EXE_B, EXE_writereg_num};
    endfunction

    task automatic drive(input logic rw, input logic m2r, input logic mw, input logic jal,
                         input logic alua, input logic alub, input logic [3:0] op,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] wr);
        EXE_RegWrite = rw;  EXE_mem_to_reg = m2r; EXE_memwrite = mw; EXE_jal = jal;
        EXE_alua = alua;    EXE_alub = alub;      EXE_aluOp = op;    EXE_PC = pc;
        EXE_A = a;          EXE_B = b;            EXE_IMM32 = imm;   EXE_writereg_num = wr;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 1, 1, 0, 0, 0, 4'd12, 32'h4, 32'h3, 32'h5, 32'h0, 5'd9);
        #1;
        checks++;
        if (observed() !== exp_t'('0)) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", observed());
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        checks++;
        if (observed() !== exp_t'('0)) begin
            errors++; $display("FAIL reset_held: got %h expected 0", observed());
        end
        drive(0, 0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_add();
        exp_t got, exp;
        drive(1, 0, 0, 0, 0, 0, 4'd0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd5);
        sb.push_back(predict());
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL add_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        got = observed(); exp = sb.pop_front();
        checks++;
        if (got !== exp || got.res !== 32'h0 || got.wr !== 5'd5) begin
            errors++; $display("FAIL add_wrap: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_alu();
        exp_t got, exp;
        // three fixed vectors followed by every single-cycle opcode with random operands
        for (int unsigned i = 0; i < 18; i++) begin
            if (i == 0)      drive(1, 0, 0, 0, 1, 0, 4'd10, 32'h0, 32'h0, 32'h8000_0000, 32'h100, 5'd1);
            else if (i == 1) drive(1, 0, 0, 0, 0, 0, 4'd6, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd2);
            else if (i == 2) drive(1, 0, 0, 0, 0, 0, 4'd7, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd3);
            else begin
                logic [3:0] op;
                op = 4'(i - 3);
                if (op >= 4'd12) op = op + 4'd1;
                drive(1'($urandom), 1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom),
                      op, $urandom, $urandom, $urandom, $urandom, 5'($urandom));
            end
            sb.push_back(predict());
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL alu_stall[%0d]: got %b expected 0", i, stall);
            end
            @(posedge clk); #1;
            got = observed(); exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL alu_op[%0d] op=%0d: got %h expected %h", i, EXE_aluOp, got, exp);
            end
            if (i < 3) begin
                checks++;
                if (got.res !== ((i == 0) ? 32'hF800_0000 : (i == 1) ? 32'h1 : 32'h0)) begin
                    errors++; $display("FAIL alu_vector[%0d]: got %h", i, got.res);
                end
            end
        end
    endtask

    task automatic test_mul();
        exp_t got, exp;
        int n;
        drive(1, 1, 0, 0, 0, 0, 4'd12, 32'h0, 32'h0001_2345, 32'h0000_0100, 32'h0, 5'd7);
        sb.push_back(predict());
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            checks++;
            if (observed() !== exp_t'('0)) begin
                errors++; $display("FAIL mul_bubble[%0d]: got %h expected 0", n, observed());
            end
        end
        checks++;
        if (n != 33) begin
            errors++; $display("FAIL mul_stall_len: got %0d expected 33", n);
        end
        @(posedge clk); #1;
        got = observed(); exp = sb.pop_front();
        checks++;
        if (got !== exp || got.res !== 32'h0123_4500) begin
            errors++; $display("FAIL mul_result: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_jal();
        exp_t got, exp;
        drive(1, 0, 0, 1, 0, 0, 4'd12, 32'h0040_0008, 32'h11, 32'h22, 32'h0, 5'd31);
        sb.push_back(predict());
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL jal_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        got = observed(); exp = sb.pop_front();
        checks++;
        if (got !== exp || got.res !== 32'h0040_0008 || got.wr !== 5'd31) begin
            errors++; $display("FAIL jal_link: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t got, exp;
        drive(1, 0, 1, 0, 0, 0, 4'd12, 32'h0, 32'h1234, 32'h5678, 32'h0, 5'd4);
        #1;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL midmul_busy: got %b expected 1", stall);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (observed() !== exp_t'('0) || stall !== 1'b0) begin
            errors++; $display("FAIL midmul_abort: got %h stall %b expected 0 stall 0", observed(), stall);
        end
        drive(1, 0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h7, 32'h9, 32'h0, 5'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.push_back(predict());
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL midmul_release_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        got = observed(); exp = sb.pop_front();
        checks++;
        if (got !== exp || got.res !== 32'h10) begin
            errors++; $display("FAIL midmul_add: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, exp;
        int n;
        for (int unsigned i = 0; i < 2; i++) begin
            if (i == 0) drive(1, 0, 0, 0, 0, 0, 4'd12, 32'h0, 32'h3, 32'h5, 32'h0, 5'd10);
            else        drive(1, 0, 0, 0, 0, 0, 4'd12, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd11);
            sb.push_back(predict());
            #1;
            n = 0;
            while (stall === 1'b1 && n < 100) begin
                n++;
                @(posedge clk); #1;
                checks++;
                if (observed() !== exp_t'('0)) begin
                    errors++; $display("FAIL b2b_bubble[%0d.%0d]: got %h expected 0", i, n, observed());
                end
            end
            checks++;
            if (n != 33) begin
                errors++; $display("FAIL b2b_stall_len[%0d]: got %0d expected 33", i, n);
            end
            @(posedge clk); #1;
            got = observed(); exp = sb.pop_front();
            checks++;
            if (got !== exp || got.res !== ((i == 0) ? 32'd15 : 32'd1)) begin
                errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_mul();
        test_jal();
        test_reset_mid_mul();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: got %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have inputs EXE_RegWrite, EXE_mem_to_reg, EXE_memwrite, EXE_jal, EXE_alua, EXE_alub, each 1 bit: control fields from the ID/EXE pipeline register.
REQ-004 SHALL have input EXE_aluOp, 4 bits: ALU operation select.
REQ-005 SHALL have inputs EXE_PC, EXE_A, EXE_B, EXE_IMM32, each 32 bits: link address (already PC+4), register operands, extended immediate.
REQ-006 SHALL have input EXE_writereg_num, 5 bits: destination register.
REQ-007 SHALL have outputs MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite, each 1 bit, registered: control forwarded to MEM.
REQ-008 SHALL have outputs MEM_result and MEM_B, each 32 bits, registered: EXE result; store data (raw EXE_B).
REQ-009 SHALL have output MEM_writereg_num, 5 bits, registered.
REQ-010 SHALL have output stall, 1 bit, combinational: upstream SHALL hold all EXE_* inputs stable while stall=1.

Function
REQ-011 SHALL form operand X = {27'b0, EXE_IMM32[10:6]} when EXE_alua=1, else EXE_A.
REQ-012 SHALL form operand Y = EXE_IMM32 when EXE_alub=1, else EXE_B.
REQ-013 SHALL compute by EXE_aluOp: 0 X+Y; 1 X-Y; 2 X&Y; 3 X|Y; 4 X^Y; 5 ~(X|Y); 6 signed X<Y ? 1:0; 7 unsigned X<Y ? 1:0; 8 Y<<X[4:0]; 9 Y>>X[4:0] logical; 10 Y>>>X[4:0] arithmetic; 11 Y<<16; 12 MUL; 13-15 result 0.
REQ-014 SHALL produce 32-bit wrap-around for ADD/SUB/MUL; no overflow flag, no trap.
REQ-015 SHALL select EXE_PC as the result when EXE_jal=1, overriding aluOp; no multiply starts when EXE_jal=1.
REQ-016 SHALL implement MUL as iterative unsigned shift-add, one partial-product step per cycle, keeping the low 32 bits of X*Y (identical for signed operands).
REQ-017 SHALL use multiply FSM states IDLE, BUSY, DONE with 5-bit iteration counter.
REQ-018 IDLE: if aluOp=12 and jal=0, SHALL load multiplicand=X, multiplier=Y, accumulator=0, counter=0, assert stall, go BUSY; otherwise stall=0 and stay IDLE.
REQ-019 BUSY: SHALL assert stall, perform one step per cycle, go DONE when counter=31 (32 steps total).
REQ-020 DONE: SHALL deassert stall, present accumulator as result, return to IDLE.
REQ-021 SHALL hold stall=1 for exactly 33 consecutive cycles per MUL; product SHALL be captured into MEM_result at the posedge ending the DONE cycle.
REQ-022 Back-to-back MUL: IDLE after DONE SHALL start the next multiply with no extra gap cycle.
REQ-023 On every posedge with stall=0, SHALL register: MEM_RegWrite, MEM_mem_to_reg, MEM_memwrite, MEM_writereg_num from EXE_* inputs; MEM_result from result; MEM_B from EXE_B.
REQ-024 On every posedge with stall=1, SHALL load a bubble: MEM_RegWrite=0, MEM_memwrite=0, MEM_mem_to_reg=0, MEM_writereg_num=0, MEM_result=0, MEM_B=0.
REQ-025 Single-cycle ops (all except MUL) SHALL have 1-cycle latency, EXE inputs to MEM outputs.

Reset
REQ-026 While rst=0: all MEM_* outputs SHALL be 0, FSM SHALL be IDLE, counter, multiplicand, multiplier, accumulator SHALL be 0.
REQ-027 rst asserted mid-multiply SHALL abort it; stall SHALL fall to 0 once state is IDLE, subject only to current inputs.
REQ-028 After rst returns to 1, first posedge SHALL behave as IDLE with no pending operation.

Verification
REQ-029 aluOp=0, A=0xFFFFFFFF, B=1, alua=alub=0, RegWrite=1, writereg=5 -> next posedge MEM_result=0, MEM_RegWrite=1, MEM_writereg_num=5, stall=0 throughout.
REQ-030 aluOp=10, alua=1, IMM32[10:6]=4, B=0x80000000 -> MEM_result=0xF8000000; aluOp=6, A=0xFFFFFFFF, B=0 -> 1; aluOp=7 same operands -> 0.
REQ-031 aluOp=12, A=0x00012345, B=0x00000100, held stable -> stall=1 for 33 cycles, MEM bubbles meanwhile, then MEM_result=0x01234500 with original control fields.
REQ-032 jal=1, aluOp=12, PC=0x00400008, writereg=31 -> no stall, next posedge MEM_result=0x00400008, MEM_writereg_num=31.
REQ-033 Start MUL, drive rst=0 at iteration 10 -> MEM_* immediately 0, stall=0; release rst with aluOp=0 -> normal 1-cycle ADD result.
REQ-034 Two consecutive MULs (3*5 then 0xFFFFFFFF*0xFFFFFFFF) -> results 15 then 0x00000001, each with exactly 33 stall cycles, no gap between them.
